// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file and scoreboard.
// Holds default sizes, reset-content encodings and the address-width function.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_NUM_REGS   = 32;

  localparam int INIT_ZERO = 0;
  localparam int INIT_IDX  = 1;

  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port with write-to-read bypass and busy masking.
// Register 0 and the reset window always read as zero and not busy.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int ADDR_W     = addr_w(DEF_NUM_REGS)
) (
  input  logic                                reset_i,
  input  logic [ADDR_W-1:0]                   addr_i,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_i,
  input  logic [NUM_REGS-1:0]                 busy_i,
  input  logic                                wr_en_i,
  input  logic [ADDR_W-1:0]                   wr_addr_i,
  input  logic [DATA_WIDTH-1:0]               wr_data_i,
  output logic [DATA_WIDTH-1:0]               data_o,
  output logic                                busy_o
);

  logic bypass;

  // Select stored value, override with in-flight writeback, then force zero.
  always_comb begin
    bypass = wr_en_i && (wr_addr_i != '0)
          && (wr_addr_i == addr_i);
    data_o = regs_i[addr_i];
    busy_o = busy_i[addr_i];
    if (bypass) begin
      data_o = wr_data_i;
      busy_o = 1'b0;
    end
    if (reset_i || (addr_i == '0)) begin
      data_o = '0;
      busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Issue reserves destinations; writeback fills them and clears busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int NUM_RD_PORTS = 2,
  parameter int INIT_INDEX   = INIT_IDX,
  localparam int ADDR_W      = addr_w(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]      rd_busy,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rsv_en,
  input  logic [ADDR_W-1:0]            rsv_addr,
  output logic                         rsv_ready,
  output logic [ADDR_W:0]              busy_count
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
  logic [NUM_REGS-1:0]                 busy_q, busy_d;
  logic [ADDR_W:0]                     count_q, count_d;
  logic                                clr, set, inc, dec;

  // Scoreboard next state: writeback clears first, reservation sets after.
  always_comb begin
    rsv_ready = ~busy_q[rsv_addr]
             || (rsv_addr == '0)
             || (wr_en && (wr_addr == rsv_addr));
    clr = wr_en && (wr_addr != '0);
    set = rsv_en && rsv_ready && (rsv_addr != '0);
    inc = set && !busy_q[rsv_addr];
    dec = clr && busy_q[wr_addr]
       && !(set && (rsv_addr == wr_addr));
    busy_d = busy_q;
    if (clr) busy_d[wr_addr] = 1'b0;
    if (set) busy_d[rsv_addr] = 1'b1;
    count_d = count_q
            + (ADDR_W+1)'(inc)
            - (ADDR_W+1)'(dec);
  end

  // Storage, busy bits and busy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (INIT_INDEX == INIT_IDX)
                   ? DATA_WIDTH'(i) : '0;
      end
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      if (clr) regs_q[wr_addr] <= wr_data;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_count = count_q;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ADDR_W     (ADDR_W)
    ) u_port (
      .reset_i   (reset),
      .addr_i    (rd_addr[p*ADDR_W +: ADDR_W]),
      .regs_i    (regs_q),
      .busy_i    (busy_q),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .data_o    (rd_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .busy_o    (rd_busy[p])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two instances (index and zero reset)
// driven in lockstep and compared against an array-based reference.
module tb_regfile_scoreboard;

  localparam int DW = 64;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NP = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP*AW-1:0] rd_addr;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            rsv_en;
  logic [AW-1:0]   rsv_addr;

  logic [NP*DW-1:0] rd_data_a, rd_data_b;
  logic [NP-1:0]    rd_busy_a, rd_busy_b;
  logic             rsv_ready_a, rsv_ready_b;
  logic [AW:0]      busy_count_a, busy_count_b;

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .DATA_WIDTH(DW), .NUM_REGS(NR),
    .NUM_RD_PORTS(NP), .INIT_INDEX(1)
  ) u_a (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_ready(rsv_ready_a),
    .busy_count(busy_count_a)
  );

  regfile_scoreboard #(
    .DATA_WIDTH(DW), .NUM_REGS(NR),
    .NUM_RD_PORTS(NP), .INIT_INDEX(0)
  ) u_b (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_ready(rsv_ready_b),
    .busy_count(busy_count_b)
  );

  // reference state: [0] zero-reset copy, [1] index-reset copy
  logic [DW-1:0] m_mem [2][NR];
  bit            m_busy [NR];
  bit            primed;
  int            checks;
  int            fails;

  task automatic check_eq(input string tag,
                          input logic [DW-1:0] got,
                          input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(int k,
                                           logic [AW-1:0] a);
    if (reset) return '0;
    if (a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_mem[k][a];
  endfunction

  function automatic logic exp_busy(logic [AW-1:0] a);
    if (reset || a == 0) return 1'b0;
    if (wr_en && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_ready();
    return !m_busy[rsv_addr] || rsv_addr == 0
        || (wr_en && wr_addr == rsv_addr);
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic compare_all();
    logic [AW-1:0] a;
    for (int p = 0; p < NP; p++) begin
      a = rd_addr[p*AW +: AW];
      check_eq($sformatf("rd_a_p%0d", p),
               rd_data_a[p*DW +: DW], exp_rd(1, a));
      check_eq($sformatf("rd_b_p%0d", p),
               rd_data_b[p*DW +: DW], exp_rd(0, a));
      check_eq($sformatf("busy_a_p%0d", p),
               DW'(rd_busy_a[p]), DW'(exp_busy(a)));
      check_eq($sformatf("busy_b_p%0d", p),
               DW'(rd_busy_b[p]), DW'(exp_busy(a)));
    end
    if (primed) begin
      check_eq("ready_a", DW'(rsv_ready_a), DW'(exp_ready()));
      check_eq("ready_b", DW'(rsv_ready_b), DW'(exp_ready()));
      check_eq("count_a", DW'(busy_count_a), DW'(exp_cnt()));
      check_eq("count_b", DW'(busy_count_b), DW'(exp_cnt()));
    end
  endtask

  task automatic drive(input bit rst,
                       input bit we, input int wa,
                       input logic [DW-1:0] wd,
                       input bit re, input int ra,
                       input int a0, input int a1);
    @(negedge clk);
    reset    = rst;
    wr_en    = we;
    wr_addr  = AW'(wa);
    wr_data  = wd;
    rsv_en   = re;
    rsv_addr = AW'(ra);
    rd_addr  = {AW'(a1), AW'(a0)};
    #1;
    compare_all();
  endtask

  task automatic commit();
    bit rdy;
    @(posedge clk);
    rdy = exp_ready();
    if (reset) begin
      for (int i = 0; i < NR; i++) begin
        m_mem[1][i] = DW'(i);
        m_mem[0][i] = '0;
        m_busy[i]   = 1'b0;
      end
      primed = 1'b1;
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_mem[0][wr_addr] = wr_data;
        m_mem[1][wr_addr] = wr_data;
        m_busy[wr_addr]   = 1'b0;
      end
      if (rsv_en && rdy && rsv_addr != 0)
        m_busy[rsv_addr] = 1'b1;
    end
  endtask

  task automatic step(input bit rst,
                      input bit we, input int wa,
                      input logic [DW-1:0] wd,
                      input bit re, input int ra,
                      input int a0, input int a1);
    drive(rst, we, wa, wd, re, ra, a0, a1);
    commit();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    primed = 1'b0;
    for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;

    step(1, 1, 9, 64'h55, 1, 9, 3, 9);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // reset contents
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    check_eq("r5_init", rd_data_a[DW-1:0], 64'd5);
    check_eq("r0_read", rd_data_a[2*DW-1:DW], 64'd0);
    check_eq("r5_busy", DW'(rd_busy_a[0]), 64'd0);
    check_eq("cnt_init", DW'(busy_count_a), 64'd0);
    commit();

    // bypass then stored value
    drive(0, 1, 7, 64'hDEAD_BEEF, 0, 0, 7, 7);
    check_eq("r7_bypass", rd_data_a[DW-1:0], 64'hDEAD_BEEF);
    commit();
    drive(0, 0, 0, 0, 0, 0, 7, 0);
    check_eq("r7_stored", rd_data_a[DW-1:0], 64'hDEAD_BEEF);
    commit();

    // reservation and RAW hazard
    drive(0, 0, 0, 0, 1, 3, 3, 0);
    check_eq("rsv3_ready", DW'(rsv_ready_a), 64'd1);
    commit();
    drive(0, 0, 0, 0, 1, 3, 3, 0);
    check_eq("rsv3_again", DW'(rsv_ready_a), 64'd0);
    check_eq("cnt_one", DW'(busy_count_a), 64'd1);
    check_eq("r3_busy", DW'(rd_busy_a[0]), 64'd1);
    commit();
    drive(0, 1, 3, 64'd42, 0, 0, 0, 0);
    check_eq("cnt_stall", DW'(busy_count_a), 64'd1);
    commit();
    drive(0, 0, 0, 0, 0, 0, 3, 0);
    check_eq("r3_42", rd_data_a[DW-1:0], 64'd42);
    check_eq("cnt_clr", DW'(busy_count_a), 64'd0);
    commit();

    // write and reserve same busy register
    step(0, 0, 0, 0, 1, 3, 0, 0);
    drive(0, 1, 3, 64'd77, 1, 3, 3, 0);
    check_eq("wr_rsv_ready", DW'(rsv_ready_a), 64'd1);
    commit();
    drive(0, 0, 0, 0, 0, 0, 3, 0);
    check_eq("r3_77", rd_data_a[DW-1:0], 64'd77);
    check_eq("r3_still_busy", DW'(rd_busy_a[0]), 64'd1);
    check_eq("cnt_same", DW'(busy_count_a), 64'd1);
    commit();
    step(0, 1, 3, 64'd5, 0, 0, 0, 0);

    // register 0
    drive(0, 1, 0, 64'hFFFF, 1, 0, 0, 0);
    check_eq("r0_ready", DW'(rsv_ready_a), 64'd1);
    check_eq("r0_bypass", rd_data_a[DW-1:0], 64'd0);
    commit();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("r0_after", rd_data_a[DW-1:0], 64'd0);
    check_eq("r0_cnt", DW'(busy_count_a), 64'd0);
    commit();

    // reset mid-sequence
    step(0, 0, 0, 0, 1, 1, 1, 2);
    step(0, 0, 0, 0, 1, 2, 1, 2);
    step(0, 0, 0, 0, 1, 4, 4, 2);
    step(1, 1, 4, 64'h99, 1, 5, 4, 1);
    drive(0, 0, 0, 0, 0, 0, 4, 1);
    check_eq("rst_cnt", DW'(busy_count_a), 64'd0);
    check_eq("rst_busy", DW'(rd_busy_a[0]), 64'd0);
    check_eq("rst_r4_idx", rd_data_a[DW-1:0], 64'd4);
    check_eq("rst_r4_zero", rd_data_b[DW-1:0], 64'd0);
    commit();

    // randomized traffic over a small hot address set
    for (int n = 0; n < 800; n++) begin
      int wa, ra, a0, a1;
      wa = (n % 3 == 0) ? int'($urandom_range(0, 31))
                        : int'($urandom_range(0, 7));
      ra = int'($urandom_range(0, 7));
      a0 = int'($urandom_range(0, 7));
      a1 = (n % 4 == 0) ? wa : int'($urandom_range(0, 31));
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 1) == 1, wa,
           {$urandom, $urandom},
           $urandom_range(0, 1) == 1, ra, a0, a1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
